// File: rtl/lenet_pkg.sv
// Shared LeNet constants, the argmax FSM state type and a counter-width helper.
package lenet_pkg;

   localparam int LENET_NCLS  = 10;
   localparam int LENET_L5_DW = 32;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SCAN = 2'd1,
      DONE = 2'd2
   } argmax_state_t;

   // Bits needed to count 0..n-1, never less than one.
   function automatic int clog2_min1(input int n);
      int w;
      w = 1;
      while ((1 << w) < n) w++;
      return w;
   endfunction

endpackage

// File: rtl/layer5_argmax_if.sv
// Score/result bundle between layer 5 and the argmax stage; max_score only with LAYER5_ARGMAX_SCORE_OUT_EN.
interface layer5_argmax_if
   import lenet_pkg::*;
#(
   parameter int NCLS = LENET_NCLS,
   parameter int DW   = LENET_L5_DW
);
   logic                 start;
   logic [NCLS*DW-1:0]   scores;
   logic [3:0]           class_idx;
   logic                 class_valid;
   logic                 busy;
   logic                 overrun;
`ifdef LAYER5_ARGMAX_SCORE_OUT_EN
   logic [DW-1:0]        max_score;

   modport master (output start, scores,
                   input  class_idx, class_valid, busy, overrun, max_score);
   modport slave  (input  start, scores,
                   output class_idx, class_valid, busy, overrun, max_score);
`else
   modport master (output start, scores,
                   input  class_idx, class_valid, busy, overrun);
   modport slave  (input  start, scores,
                   output class_idx, class_valid, busy, overrun);
`endif
endinterface

// File: rtl/layer5_argmax.sv
// Sequential argmax over NCLS captured signed scores; result pulse NCLS cycles after start.
// No backpressure: start while busy is dropped and flagged on overrun. LAYER5_ARGMAX_SCORE_OUT_EN adds max_score.
module layer5_argmax
   import lenet_pkg::*;
#(
   parameter int NCLS = LENET_NCLS,
   parameter int DW   = LENET_L5_DW
) (
   input  logic           clk,
   input  logic           reset_n,
   layer5_argmax_if.slave bus
);
   localparam int            IW   = clog2_min1(NCLS);
   localparam logic [IW-1:0] LAST = IW'(NCLS - 1);

   argmax_state_t        state, state_nxt;
   logic signed [DW-1:0] bank [NCLS];
   logic [IW-1:0]        idx;
   logic [3:0]           best_idx;
   logic signed [DW-1:0] best_val;
   logic signed [DW-1:0] cand_val;
   logic                 take;
   logic                 at_last;
   logic [3:0]           sel_idx;
   logic signed [DW-1:0] sel_val;
   logic [3:0]           class_r;
   logic                 valid_r;
   logic                 overrun_r;

   assign at_last  = (idx == LAST);
   assign cand_val = bank[idx];
   // Strict compare keeps the earlier index on ties.
   assign take     = (cand_val > best_val);
   assign sel_idx  = take ? 4'(idx) : best_idx;
   assign sel_val  = take ? cand_val : best_val;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state <= IDLE;
      else          state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (bus.start) state_nxt = SCAN;
         SCAN:    if (at_last)   state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

`ifdef LAYER5_ARGMAX_SCORE_OUT_EN
   logic signed [DW-1:0] max_r;
   assign bus.max_score = max_r;
`endif

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < NCLS; i++) bank[i] <= '0;
         idx       <= '0;
         best_idx  <= '0;
         best_val  <= '0;
         class_r   <= '0;
         valid_r   <= 1'b0;
         overrun_r <= 1'b0;
`ifdef LAYER5_ARGMAX_SCORE_OUT_EN
         max_r     <= '0;
`endif
      end else begin
         valid_r <= 1'b0;
         if (bus.start) overrun_r <= (state != IDLE);
         case (state)
            IDLE: begin
               if (bus.start) begin
                  for (int i = 0; i < NCLS; i++) bank[i] <= bus.scores[i*DW +: DW];
                  best_idx <= '0;
                  best_val <= bus.scores[DW-1:0];
                  idx      <= IW'(1);
               end
            end
            SCAN: begin
               best_idx <= sel_idx;
               best_val <= sel_val;
               // Final compare lands the result so it is visible during DONE.
               if (at_last) begin
                  class_r <= sel_idx;
                  valid_r <= 1'b1;
`ifdef LAYER5_ARGMAX_SCORE_OUT_EN
                  max_r   <= sel_val;
`endif
               end else begin
                  idx <= idx + IW'(1);
               end
            end
            default: ;
         endcase
      end
   end

   assign bus.class_idx   = class_r;
   assign bus.class_valid = valid_r;
   assign bus.busy        = (state != IDLE);
   assign bus.overrun     = overrun_r;

endmodule

// File: tb/tb_layer5_argmax.sv
// Scoreboard bench for layer5_argmax: directed corner vectors plus random score sets.
module tb_layer5_argmax;
   import lenet_pkg::*;

   localparam int NCLS = LENET_NCLS;
   localparam int DW   = LENET_L5_DW;

   typedef logic [NCLS*DW-1:0] vec_t;
   typedef int                 arr_t [NCLS];
   typedef struct {
      int     cls;
      longint mx;
      longint due;
   } exp_t;

   logic   clk = 1'b0;
   logic   reset_n = 1'b0;
   longint cyc = 0;
   int     n_cmp = 0;
   int     n_bad = 0;
   exp_t   sb[$];
   exp_t   mon_e;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   layer5_argmax_if #(.NCLS(NCLS), .DW(DW)) bus ();

   layer5_argmax #(.NCLS(NCLS), .DW(DW)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus.slave)
   );

   task automatic check(input string name, input longint act, input longint exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic vec_t pack(input arr_t v);
      vec_t s;
      for (int i = 0; i < NCLS; i++) s[i*DW +: DW] = v[i];
      return s;
   endfunction

   // Reference: maximum value first, then the first index holding it.
   function automatic exp_t model(input vec_t s);
      exp_t   e;
      longint v [NCLS];
      for (int i = 0; i < NCLS; i++) v[i] = longint'($signed(s[i*DW +: DW]));
      e.mx = v[0];
      foreach (v[i]) if (v[i] > e.mx) e.mx = v[i];
      e.cls = -1;
      foreach (v[i]) if (e.cls < 0 && v[i] == e.mx) e.cls = i;
      e.due = 0;
      return e;
   endfunction

   // Called at a negedge; start is sampled at the following posedge.
   task automatic issue(input vec_t s, input bit expect_result);
      exp_t e;
      bus.start  = 1'b1;
      bus.scores = s;
      if (expect_result) begin
         e     = model(s);
         e.due = cyc + NCLS;
         sb.push_back(e);
      end
      @(negedge clk);
      bus.start  = 1'b0;
      bus.scores = ~s;
   endtask

   task automatic run(input vec_t s);
      issue(s, 1'b1);
      repeat (NCLS) @(negedge clk);
   endtask

   always @(negedge clk) begin
      if (reset_n && bus.class_valid) begin
         if (sb.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_valid: class_valid=1 at cycle %0d, required 0", cyc);
         end else begin
            mon_e = sb.pop_front();
            check("class", longint'(bus.class_idx), longint'(mon_e.cls));
            check("latency_cycle", cyc, mon_e.due);
`ifdef LAYER5_ARGMAX_SCORE_OUT_EN
            check("max_score", longint'($signed(bus.max_score)), mon_e.mx);
`endif
         end
      end
   end

   initial begin
      arr_t a;
      vec_t s;
      int   mode;
      bus.start  = 1'b0;
      bus.scores = '0;
      reset_n    = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_class", longint'(bus.class_idx), 0);
      check("rst_valid", longint'(bus.class_valid), 0);
      check("rst_busy", longint'(bus.busy), 0);
      check("rst_overrun", longint'(bus.overrun), 0);
`ifdef LAYER5_ARGMAX_SCORE_OUT_EN
      check("rst_max_score", longint'($signed(bus.max_score)), 0);
`endif
      reset_n = 1'b1;
      @(negedge clk);

      // Tie between indices 2 and 5, plus busy window.
      issue(pack('{3, -7, 12, 0, 5, 12, -1, 4, 9, 2}), 1'b1);
      for (int k = 1; k <= NCLS; k++) begin
         check("busy_window", longint'(bus.busy), 1);
         @(negedge clk);
      end
      check("busy_after", longint'(bus.busy), 0);

      foreach (a[i]) a[i] = -100;
      run(pack(a));
      foreach (a[i]) a[i] = 0;
      a[NCLS-1] = 32'h7FFF_FFFF;
      run(pack(a));
      foreach (a[i]) a[i] = -5;
      a[4] = -1;
      a[7] = 32'h8000_0000;
      run(pack(a));

      // Start during a scan is dropped; the first capture decides the result.
      foreach (a[i]) a[i] = int'($urandom);
      issue(pack(a), 1'b1);
      repeat (3) @(negedge clk);
      foreach (a[i]) a[i] = 32'h7FFF_FFFF;
      bus.start  = 1'b1;
      bus.scores = pack(a);
      @(negedge clk);
      bus.start = 1'b0;
      check("overrun_set", longint'(bus.overrun), 1);
      repeat (6) @(negedge clk);
      check("overrun_sticky", longint'(bus.overrun), 1);
      foreach (a[i]) a[i] = i;
      issue(pack(a), 1'b1);
      check("overrun_cleared", longint'(bus.overrun), 0);
      repeat (NCLS) @(negedge clk);

      // Reset mid-scan with overrun set and a nonzero previous class.
      foreach (a[i]) a[i] = int'($urandom);
      issue(pack(a), 1'b0);
      repeat (2) @(negedge clk);
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      @(negedge clk);
      reset_n = 1'b0;
      #1;
      check("midrst_class", longint'(bus.class_idx), 0);
      check("midrst_valid", longint'(bus.class_valid), 0);
      check("midrst_busy", longint'(bus.busy), 0);
      check("midrst_overrun", longint'(bus.overrun), 0);
`ifdef LAYER5_ARGMAX_SCORE_OUT_EN
      check("midrst_max_score", longint'($signed(bus.max_score)), 0);
`endif
      repeat (3) @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);
      check("post_rst_busy", longint'(bus.busy), 0);
      foreach (a[i]) a[i] = int'($urandom_range(0, 40)) - 20;
      run(pack(a));

      for (int n = 0; n < 30; n++) begin
         mode = int'($urandom_range(0, 2));
         foreach (a[i]) begin
            case (mode)
               0:       a[i] = int'($urandom);
               1:       a[i] = int'($urandom_range(0, 6)) - 3;
               default: begin
                  case ($urandom_range(0, 3))
                     0:       a[i] = 32'h8000_0000;
                     1:       a[i] = 32'h7FFF_FFFF;
                     2:       a[i] = 0;
                     default: a[i] = -1;
                  endcase
               end
            endcase
         end
         run(pack(a));
         repeat ($urandom_range(0, 2)) @(negedge clk);
      end

      for (int w = 0; w < 4 * NCLS && sb.size() != 0; w++) @(negedge clk);
      check("scoreboard_drained", longint'(sb.size()), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
